// File: rtl/tlul_pkg.sv
// Shared TL-UL constants, default widths and GPIO register offsets.
package tlul_pkg;

  localparam int unsigned TlAddrWidth = 32;
  localparam int unsigned TlDataWidth = 32;
  localparam int unsigned TlSrcWidth  = 2;
  localparam int unsigned TlSinkWidth = 1;

  // A-channel opcodes
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

  // GPIO register offsets within the 4 KiB region
  localparam logic [11:0] OffDataOut   = 12'h000;
  localparam logic [11:0] OffDataIn    = 12'h004;
  localparam logic [11:0] OffDir       = 12'h008;
  localparam logic [11:0] OffIntrEn    = 12'h00C;
  localparam logic [11:0] OffIntrState = 12'h010;

  typedef enum logic {StIdle, StResp} gpio_state_e;

endpackage

// File: rtl/tlul_gpio_slave_if.sv
// TL-UL A/D channel bundle between a host and the GPIO slave.
interface tlul_gpio_slave_if
  import tlul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = TlAddrWidth,
  parameter int unsigned SRC_WIDTH  = TlSrcWidth,
  parameter int unsigned SINK_WIDTH = TlSinkWidth
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_WIDTH-1:0]  a_source;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [3:0]            a_mask;
  logic [31:0]           a_data;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [2:0]            d_param;
  logic [2:0]            d_size;
  logic [SRC_WIDTH-1:0]  d_source;
  logic [SINK_WIDTH-1:0] d_sink;
  logic [31:0]           d_data;
  logic                  d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module tlul_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q, meta_d, sync_q, sync_d;

  // Next state: shift the input through the two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchroniser stages, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/tlul_gpio_slave.sv
// TL-UL GPIO slave: output data/direction registers, synchronised inputs and
// rising-edge interrupts, one outstanding transaction at a time.
module tlul_gpio_slave
  import tlul_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = TlAddrWidth,
  parameter int unsigned           DATA_WIDTH = TlDataWidth,
  parameter int unsigned           SRC_WIDTH  = TlSrcWidth,
  parameter int unsigned           SINK_WIDTH = TlSinkWidth,
  parameter int unsigned           GPIO_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_MASK  = ADDR_WIDTH'(32'hFFFF_F000)
) (
  input  logic                  clk,
  input  logic                  reset,
  tlul_gpio_slave_if.slave      tl,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  intr
);
  localparam logic [DATA_WIDTH-1:0] GpioMask = DATA_WIDTH'((64'd1 << GPIO_WIDTH) - 64'd1);

  gpio_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d, dir_q, dir_d;
  logic [DATA_WIDTH-1:0] intr_en_q, intr_en_d, intr_state_q, intr_state_d;
  logic [DATA_WIDTH-1:0] gpio_prev_q, gpio_prev_d;
  logic                  intr_q, intr_d;
  logic                  d_valid_q, d_valid_d, d_error_q, d_error_d;
  logic [2:0]            d_opcode_q, d_opcode_d, d_size_q, d_size_d;
  logic [SRC_WIDTH-1:0]  d_source_q, d_source_d;
  logic [DATA_WIDTH-1:0] d_data_q, d_data_d;

  logic                  accept, op_ok, is_put, misaligned, base_hit, reg_hit, err, wr_en;
  logic [11:0]           reg_off;
  logic [DATA_WIDTH-1:0] wmask, rdata, sync_ext, rise;
  logic [GPIO_WIDTH-1:0] gpio_sync;

  tlul_sync2 #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (gpio_in),
    .q_o   (gpio_sync)
  );

  assign sync_ext = DATA_WIDTH'(gpio_sync);
  assign rise     = sync_ext & ~gpio_prev_q;

  // Ready depends only on state and reset, never on a_valid.
  assign tl.a_ready = (state_q == StIdle) && !reset;
  assign accept     = tl.a_valid && tl.a_ready;

  // Request decode: legality checks and register read mux.
  always_comb begin
    // Sub-word accesses address the containing word register.
    reg_off    = {tl.a_address[11:2], 2'b00};
    op_ok      = tl.a_opcode inside {OpGet, OpPutFullData, OpPutPartialData};
    is_put     = (tl.a_opcode == OpPutFullData) || (tl.a_opcode == OpPutPartialData);
    misaligned = 1'b0;
    case (tl.a_size)
      3'd1:    misaligned = tl.a_address[0];
      3'd2:    misaligned = |tl.a_address[1:0];
      default: misaligned = 1'b0;
    endcase
    base_hit = (tl.a_address & BASE_MASK) == BASE_ADDR;
    reg_hit  = 1'b1;
    rdata    = '0;
    unique case (reg_off)
      OffDataOut:   rdata = data_out_q;
      OffDataIn:    rdata = sync_ext;
      OffDir:       rdata = dir_q;
      OffIntrEn:    rdata = intr_en_q;
      OffIntrState: rdata = intr_state_q;
      default:      reg_hit = 1'b0;
    endcase
    err   = !op_ok || (tl.a_size > 3'd2) || misaligned || !base_hit || !reg_hit;
    wr_en = accept && !err && is_put;
    wmask = {{8{tl.a_mask[3]}}, {8{tl.a_mask[2]}}, {8{tl.a_mask[1]}}, {8{tl.a_mask[0]}}};
  end

  // Register writes, edge detection and interrupt level.
  always_comb begin
    data_out_d   = data_out_q;
    dir_d        = dir_q;
    intr_en_d    = intr_en_q;
    intr_state_d = intr_state_q;
    if (wr_en) begin
      case (reg_off)
        OffDataOut:   data_out_d = ((data_out_q & ~wmask) | (tl.a_data & wmask)) & GpioMask;
        OffDir:       dir_d = ((dir_q & ~wmask) | (tl.a_data & wmask)) & GpioMask;
        OffIntrEn:    intr_en_d = ((intr_en_q & ~wmask) | (tl.a_data & wmask)) & GpioMask;
        OffIntrState: intr_state_d = intr_state_q & ~(tl.a_data & wmask);
        default:      ;
      endcase
    end
    // A new edge wins over a simultaneous clear.
    intr_state_d = (intr_state_d | rise) & GpioMask;
    gpio_prev_d  = sync_ext;
    intr_d       = |(intr_state_q & intr_en_q);
  end

  // Transaction FSM and registered D-channel fields.
  always_comb begin
    state_d    = state_q;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StResp;
          d_valid_d  = 1'b1;
          d_opcode_d = (tl.a_opcode == OpGet) ? OpAccessAckData : OpAccessAck;
          d_size_d   = tl.a_size;
          d_source_d = tl.a_source;
          d_error_d  = err;
          d_data_d   = ((tl.a_opcode == OpGet) && !err) ? rdata : '0;
        end
      end
      StResp: begin
        if (tl.d_ready) begin
          state_d   = StIdle;
          d_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All state, cleared by synchronous reset; a pending response is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      data_out_q   <= '0;
      dir_q        <= '0;
      intr_en_q    <= '0;
      intr_state_q <= '0;
      gpio_prev_q  <= '0;
      intr_q       <= 1'b0;
      d_valid_q    <= 1'b0;
      d_opcode_q   <= '0;
      d_size_q     <= '0;
      d_source_q   <= '0;
      d_data_q     <= '0;
      d_error_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      intr_en_q    <= intr_en_d;
      intr_state_q <= intr_state_d;
      gpio_prev_q  <= gpio_prev_d;
      intr_q       <= intr_d;
      d_valid_q    <= d_valid_d;
      d_opcode_q   <= d_opcode_d;
      d_size_q     <= d_size_d;
      d_source_q   <= d_source_d;
      d_data_q     <= d_data_d;
      d_error_q    <= d_error_d;
    end
  end

  assign tl.d_valid  = d_valid_q;
  assign tl.d_opcode = d_opcode_q;
  assign tl.d_param  = '0;
  assign tl.d_size   = d_size_q;
  assign tl.d_source = d_source_q;
  assign tl.d_sink   = '0;
  assign tl.d_data   = d_data_q;
  assign tl.d_error  = d_error_q;

  assign gpio_out = data_out_q[GPIO_WIDTH-1:0];
  assign gpio_oe  = dir_q[GPIO_WIDTH-1:0];
  assign intr     = intr_q;
endmodule

// File: doc/tlul_gpio_slave.md
TLUL_GPIO_SLAVE -- requirements
Module: tlul_gpio_slave

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 32, A-channel address width.
- DATA_WIDTH, 32, data width (fixed at 32 for this block).
- SRC_WIDTH, 2, source ID width.
- SINK_WIDTH, 1, sink ID width.
- GPIO_WIDTH, 32, pin count (1..32).
- BASE_ADDR, 32'h0000_0000, region base.
- BASE_MASK, 32'hFFFF_F000, region mask.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  request valid.
- a_ready  out  1  request accept.
- a_opcode  in  3  request opcode.
- a_param  in  3  ignored.
- a_size  in  3  log2 bytes.
- a_source  in  SRC_WIDTH  source ID.
- a_address  in  ADDR_WIDTH  byte address.
- a_mask  in  4  byte enables.
- a_data  in  32  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accept.
- d_opcode  out  3  response opcode.
- d_param  out  3  always 0.
- d_size  out  3  echoed a_size.
- d_source  out  SRC_WIDTH  echoed a_source.
- d_sink  out  SINK_WIDTH  always 0.
- d_data  out  32  read data.
- d_error  out  1  error flag.
- gpio_in  in  GPIO_WIDTH  asynchronous pins.
- gpio_out  out  GPIO_WIDTH  output values.
- gpio_oe  out  GPIO_WIDTH  output enables.
- intr  out  1  level interrupt.

Function
REQ-003 SHALL map registers at offset a_address[11:0]:
- 0x00 DATA_OUT, RW.
- 0x04 DATA_IN, RO; writes ignored without error.
- 0x08 DIR, RW; 1 = output.
- 0x0C INTR_EN, RW.
- 0x10 INTR_STATE, RW1C.
REQ-004 SHALL use a two-state FSM: IDLE, RESP; reset state is IDLE.
REQ-005 SHALL drive a_ready = 1 only in IDLE with reset low; there is no combinational path from a_valid to a_ready.
REQ-006 SHALL, on a_valid && a_ready, capture source/size/opcode, perform any register write at that same edge, and enter RESP; d_valid rises exactly 1 cycle after accept.
REQ-007 SHALL, in RESP, hold d_valid=1 and all d_* fields stable until d_valid && d_ready, then return to IDLE; throughput is one transaction per 2 cycles minimum.
REQ-008 SHALL respond to Get (4) with AccessAckData (1), d_data = register value sampled at the accept edge, and unused upper bits = 0.
REQ-009 SHALL respond to PutFullData (0) and PutPartialData (1) with AccessAck (0) and d_data = 0; the write applies a_mask per byte.
REQ-010 SHALL set d_error=1, suppress all writes, and return d_data=0 (opcode AccessAckData for Get, AccessAck otherwise) when any of these hold:
- opcode not in {0,1,4};
- a_size > 2;
- address misaligned for a_size;
- (a_address & BASE_MASK) != BASE_ADDR;
- offset not in the register map.
REQ-011 SHALL synchronise gpio_in through 2 flops; DATA_IN reads the synchronised value.
REQ-012 SHALL set INTR_STATE[i] on a rising edge of synchronised gpio_in[i] (sync vs. one-cycle-delayed sync); a set and a W1C of the same bit in the same cycle leaves the bit at 1.
REQ-013 SHALL drive intr = |(INTR_STATE & INTR_EN) as a registered output, 1-cycle latency.
REQ-014 SHALL drive gpio_out = DATA_OUT and gpio_oe = DIR directly from registers.
REQ-015 SHALL ignore register bits at or above GPIO_WIDTH on write and read them as 0.

Reset
REQ-016 SHALL clear all registers, state, d_valid, intr, gpio_out, gpio_oe, and the sync flops to 0 while reset is high.
REQ-017 SHALL discard any pending response when reset is asserted in RESP; no d_valid follows release.

Structure
REQ-018 SHALL take TL-UL opcode constants (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and width defaults from shared package tlul_pkg; register offsets SHALL be localparams in tlul_pkg.
REQ-019 SHALL use one sub-module, tlul_sync2 (parameterised 2-flop synchroniser), for gpio_in.

Verification
REQ-020 Put 0x00 data 0xA5A5_A5A5 mask 0xF, then Get 0x00 -> AccessAck then AccessAckData 0xA5A5_A5A5, d_error=0, gpio_out=0xA5A5_A5A5.
REQ-021 PutPartial 0x08 data 0xFFFF_FFFF mask 0x2 -> DIR=0x0000_FF00, gpio_oe matches; hold d_ready=0 for 5 cycles -> d_* stable and a_ready=0 throughout.
REQ-022 INTR_EN=0x1, gpio_in[0] 0->1 -> INTR_STATE=0x1 after 3 cycles, intr=1 one cycle later; W1C 0x1 coincident with a new edge -> bit stays 1.
REQ-023 Get 0x14, opcode 2, a_size 3, address 0x1000 -> each gives d_error=1, d_data=0, no register change.
REQ-024 Assert reset during RESP -> d_valid=0 next cycle, all outputs 0, a_ready=1 after release.
